// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seven_seg_scan_ctrl_pkg;

   // Segment bus value with every segment dark (active-low a..g).
   localparam logic [6:0] SEG_OFF = 7'h7F;

   // All-ones digit-enable pattern; slice to the digit count in use.
   localparam logic [31:0] AN_OFF = 32'hFFFF_FFFF;

   // Scan sequencer states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2
   } state_t;

endpackage

// File: rtl/seven_seg_scan_ctrl_sevenseg.sv
// Combinational hex-to-seven-segment decoder, active-low, seg_n[6]=a ... seg_n[0]=g.
module seven_seg_scan_ctrl_sevenseg (
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   // Glyph lookup for 0-9, A, b, C, d, E, F.
   always_comb begin
      seg_n = 7'h7F;
      case (nibble)
         4'h0: seg_n = 7'h01;
         4'h1: seg_n = 7'h4F;
         4'h2: seg_n = 7'h12;
         4'h3: seg_n = 7'h06;
         4'h4: seg_n = 7'h4C;
         4'h5: seg_n = 7'h24;
         4'h6: seg_n = 7'h20;
         4'h7: seg_n = 7'h0F;
         4'h8: seg_n = 7'h00;
         4'h9: seg_n = 7'h04;
         4'hA: seg_n = 7'h08;
         4'hB: seg_n = 7'h60;
         4'hC: seg_n = 7'h31;
         4'hD: seg_n = 7'h42;
         4'hE: seg_n = 7'h30;
         4'hF: seg_n = 7'h38;
         default: seg_n = 7'h7F;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode display.
// New contents land in a shadow register and are committed only at a frame
// wrap (or right away while idle), so a frame never mixes old and new digits.
module seven_seg_scan_ctrl
   import seven_seg_scan_ctrl_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int TICK_DIV   = 1000,
   parameter int GAP_CYC    = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [4*NUM_DIGITS-1:0]       wr_data,
   input  logic [NUM_DIGITS-1:0]         wr_blank,
   input  logic [NUM_DIGITS-1:0]         wr_dp,
   output logic [NUM_DIGITS-1:0]         an_n,
   output logic [6:0]                    seg_n,
   output logic                          dp_n,
   output logic [$clog2(NUM_DIGITS)-1:0] cur_digit,
   output logic                          frame_start
);

   localparam int CNT_MAX = (TICK_DIV > GAP_CYC) ? TICK_DIV : GAP_CYC;
   localparam int CW      = $clog2(CNT_MAX);
   localparam int IW      = $clog2(NUM_DIGITS);

   state_t                  state, state_nx;
   logic [IW-1:0]           idx, idx_nx;
   logic [CW-1:0]           cnt, cnt_nx;
   logic                    pend, pend_nx, commit;
   logic [4*NUM_DIGITS-1:0] d_data, d_data_nx, s_data, s_data_nx;
   logic [NUM_DIGITS-1:0]   d_blank, d_blank_nx, s_blank, s_blank_nx;
   logic [NUM_DIGITS-1:0]   d_dp, d_dp_nx, s_dp, s_dp_nx;
   logic [NUM_DIGITS-1:0]   an_n_nx;
   logic [6:0]              seg_n_nx, dec_seg;
   logic                    dp_n_nx, fs_nx;
   logic [3:0]              nib [NUM_DIGITS];

   // Split the committed-or-committing display word into per-digit nibbles.
   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_nib
      assign nib[k] = d_data_nx[4*k +: 4];
   end

   // Decoder sees the digit that will be lit after this edge, so its
   // output can be registered in step with the state.
   seven_seg_scan_ctrl_sevenseg u_dec (
      .nibble (nib[idx_nx]),
      .seg_n  (dec_seg)
   );

   // Next-state, handshake/commit and registered-output computation.
   always_comb begin
      state_nx   = state;
      idx_nx     = idx;
      cnt_nx     = cnt;
      pend_nx    = pend;
      commit     = 1'b0;
      fs_nx      = 1'b0;
      s_data_nx  = s_data;
      s_blank_nx = s_blank;
      s_dp_nx    = s_dp;
      d_data_nx  = d_data;
      d_blank_nx = d_blank;
      d_dp_nx    = d_dp;

      case (state)
         IDLE: begin
            commit = pend;
            if (en) begin
               state_nx = SHOW;
               idx_nx   = '0;
               cnt_nx   = '0;
               fs_nx    = 1'b1;
            end
         end
         SHOW: begin
            if (cnt == CW'(TICK_DIV - 1)) begin
               state_nx = GAP;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         GAP: begin
            if (cnt == CW'(GAP_CYC - 1)) begin
               state_nx = SHOW;
               cnt_nx   = '0;
               if (idx == IW'(NUM_DIGITS - 1)) begin
                  idx_nx = '0;
                  fs_nx  = 1'b1;
                  commit = pend;
               end else begin
                  idx_nx = idx + IW'(1);
               end
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase

      // Disable wins from any active state; a pending shadow stays put and
      // is committed once the sequencer sits in IDLE.
      if (!en && state != IDLE) begin
         state_nx = IDLE;
         idx_nx   = '0;
         cnt_nx   = '0;
         fs_nx    = 1'b0;
         commit   = 1'b0;
      end

      // Capture and commit are exclusive: capture needs pend=0, commit pend=1.
      if (wr_valid && wr_ready) begin
         s_data_nx  = wr_data;
         s_blank_nx = wr_blank;
         s_dp_nx    = wr_dp;
         pend_nx    = 1'b1;
      end
      if (commit) begin
         d_data_nx  = s_data;
         d_blank_nx = s_blank;
         d_dp_nx    = s_dp;
         pend_nx    = 1'b0;
      end

      an_n_nx  = AN_OFF[NUM_DIGITS-1:0];
      seg_n_nx = SEG_OFF;
      dp_n_nx  = 1'b1;
      if (state_nx == SHOW) begin
         dp_n_nx = ~d_dp_nx[idx_nx];
         if (!d_blank_nx[idx_nx]) begin
            an_n_nx[idx_nx] = 1'b0;
            seg_n_nx        = dec_seg;
         end
      end
   end

   // State, data and output registers; async reset forces everything dark.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         cnt         <= '0;
         pend        <= 1'b0;
         wr_ready    <= 1'b1;
         s_data      <= '0;
         s_blank     <= '0;
         s_dp        <= '0;
         d_data      <= '0;
         d_blank     <= '0;
         d_dp        <= '0;
         an_n        <= AN_OFF[NUM_DIGITS-1:0];
         seg_n       <= SEG_OFF;
         dp_n        <= 1'b1;
         cur_digit   <= '0;
         frame_start <= 1'b0;
      end else begin
         state       <= state_nx;
         idx         <= idx_nx;
         cnt         <= cnt_nx;
         pend        <= pend_nx;
         wr_ready    <= ~pend_nx;
         s_data      <= s_data_nx;
         s_blank     <= s_blank_nx;
         s_dp        <= s_dp_nx;
         d_data      <= d_data_nx;
         d_blank     <= d_blank_nx;
         d_dp        <= d_dp_nx;
         an_n        <= an_n_nx;
         seg_n       <= seg_n_nx;
         dp_n        <= dp_n_nx;
         cur_digit   <= idx_nx;
         frame_start <= fs_nx;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench: frame-position reference model vs. the scan controller.
module tb_seven_seg_scan_ctrl;

   localparam int ND = 4;
   localparam int TD = 4;
   localparam int GC = 1;
   localparam int SL = TD + GC;
   localparam int FR = ND * SL;

   logic          clk = 1'b0;
   logic          rst, en, wr_valid, wr_ready;
   logic [15:0]   wr_data;
   logic [3:0]    wr_blank, wr_dp, an_n;
   logic [6:0]    seg_n;
   logic          dp_n, frame_start;
   logic [1:0]    cur_digit;

   seven_seg_scan_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD), .GAP_CYC(GC)) dut (
      .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_data(wr_data), .wr_blank(wr_blank), .wr_dp(wr_dp), .an_n(an_n),
      .seg_n(seg_n), .dp_n(dp_n), .cur_digit(cur_digit), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   int vecs = 0;
   int fails = 0;

   // Reference model: running flag + position within the frame.
   bit          m_run, m_pend, m_fs, m_cap;
   int          m_p;
   logic [15:0] m_d, m_sd;
   logic [3:0]  m_b, m_sb, m_dpv, m_sdp;

   // Lit segments a..g for each hex glyph, active-high.
   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'h0: return 7'b1111110; 4'h1: return 7'b0110000;
         4'h2: return 7'b1101101; 4'h3: return 7'b1111001;
         4'h4: return 7'b0110011; 4'h5: return 7'b1011011;
         4'h6: return 7'b1011111; 4'h7: return 7'b1110000;
         4'h8: return 7'b1111111; 4'h9: return 7'b1111011;
         4'hA: return 7'b1110111; 4'hB: return 7'b0011111;
         4'hC: return 7'b1001110; 4'hD: return 7'b0111101;
         4'hE: return 7'b1001111; default: return 7'b1000111;
      endcase
   endfunction

   function automatic logic [15:0] expv();
      logic [3:0] an;
      logic [6:0] sg;
      logic       dp;
      int         slot;
      an = 4'hF; sg = 7'h7F; dp = 1'b1; slot = 0;
      if (m_run) begin
         slot = m_p / SL;
         if ((m_p % SL) < TD) begin
            dp = ~m_dpv[slot];
            if (!m_b[slot]) begin
               an[slot] = 1'b0;
               sg = ~glyph(m_d[slot*4 +: 4]);
            end
         end
      end
      return {an, sg, dp, 2'(slot), m_fs, ~m_pend};
   endfunction

   function automatic logic [15:0] gotv();
      return {an_n, seg_n, dp_n, cur_digit, frame_start, wr_ready};
   endfunction

   task automatic model_reset();
      m_run = 0; m_pend = 0; m_fs = 0; m_cap = 0; m_p = 0;
      m_d = '0; m_sd = '0; m_b = '0; m_sb = '0; m_dpv = '0; m_sdp = '0;
   endtask

   task automatic model_step();
      bit was_run, pp, commit;
      was_run = m_run; pp = m_pend; m_fs = 0; commit = 0;
      m_cap = wr_valid && !m_pend;
      if (!en) begin
         m_run = 0; m_p = 0;
      end else if (!m_run) begin
         m_run = 1; m_p = 0; m_fs = 1;
      end else begin
         m_p = (m_p + 1) % FR;
         m_fs = (m_p == 0);
      end
      if (pp && (!was_run || (en && m_p == 0))) commit = 1;
      if (commit) begin
         m_d = m_sd; m_b = m_sb; m_dpv = m_sdp; m_pend = 0;
      end
      if (m_cap) begin
         m_sd = wr_data; m_sb = wr_blank; m_sdp = wr_dp; m_pend = 1;
      end
   endtask

   // One clock: model follows the edge, source drops valid after a transfer.
   task automatic adv();
      @(posedge clk);
      if (!rst) model_step();
      @(negedge clk);
      if (m_cap) wr_valid = 1'b0;
   endtask

   task automatic offer(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
      wr_data = d; wr_blank = b; wr_dp = p; wr_valid = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; wr_valid = 1'b0;
      wr_data = '0; wr_blank = '0; wr_dp = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         adv();
         vecs++;
         if (gotv() !== 16'hFFF1) begin
            fails++;
            $display("FAIL reset_idle cyc %0d got %h exp %h", i, gotv(), 16'hFFF1);
         end
      end
   endtask

   task automatic test_scan();
      int fs_cnt = 0;
      offer(16'h3210, 4'h0, 4'h0);
      for (int i = 0; i < 3; i++) begin
         adv();
         vecs++;
         if (gotv() !== expv()) begin
            fails++;
            $display("FAIL idle_write cyc %0d got %h exp %h", i, gotv(), expv());
         end
      end
      en = 1'b1;
      for (int i = 0; i < 2 * FR; i++) begin
         adv();
         fs_cnt += int'(frame_start);
         vecs++;
         if (gotv() !== expv()) begin
            fails++;
            $display("FAIL scan cyc %0d got %h exp %h", i, gotv(), expv());
         end
      end
      vecs++;
      if (fs_cnt !== 2) begin
         fails++;
         $display("FAIL frame_start_count got %0d exp %0d", fs_cnt, 2);
      end
   endtask

   task automatic test_midframe();
      while (m_p != SL + 1) adv();
      offer(16'hABCD, 4'h0, 4'h0);
      for (int i = 0; i < FR + 10; i++) begin
         adv();
         vecs++;
         if (gotv() !== expv()) begin
            fails++;
            $display("FAIL midframe cyc %0d got %h exp %h", i, gotv(), expv());
         end
      end
   endtask

   task automatic test_blank_dp();
      offer(16'($urandom), 4'b0100, 4'b0001);
      for (int i = 0; i < 2 * FR + 5; i++) begin
         adv();
         vecs++;
         if (gotv() !== expv()) begin
            fails++;
            $display("FAIL blank_dp cyc %0d got %h exp %h", i, gotv(), expv());
         end
      end
   endtask

   task automatic test_en_drop();
      int guard = 0;
      offer(16'h5A7E, 4'h0, 4'h4);
      while (!(m_run && m_p == 2 * SL + 1) && guard < 4 * FR) begin
         adv(); guard++;
      end
      vecs++;
      if (guard >= 4 * FR) begin
         fails++;
         $display("FAIL en_drop_wait got timeout exp digit2");
      end
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         adv();
         vecs++;
         if (gotv() !== expv()) begin
            fails++;
            $display("FAIL en_drop cyc %0d got %h exp %h", i, gotv(), expv());
         end
      end
      en = 1'b1;
      for (int i = 0; i < FR + 5; i++) begin
         adv();
         vecs++;
         if (gotv() !== expv()) begin
            fails++;
            $display("FAIL en_restart cyc %0d got %h exp %h", i, gotv(), expv());
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         if (!wr_valid && ($urandom % 6) == 0)
            offer(16'($urandom), 4'($urandom), 4'($urandom));
         if (($urandom % 50) == 0) en = ~en;
         adv();
         vecs++;
         if (gotv() !== expv()) begin
            fails++;
            $display("FAIL random cyc %0d got %h exp %h", i, gotv(), expv());
         end
      end
   endtask

   task automatic test_reset_pending();
      int guard = 0;
      en = 1'b1;
      while (!(m_run && m_p == SL) && guard < 4 * FR) begin
         adv(); guard++;
      end
      offer(16'h9876, 4'h0, 4'hF);
      adv();
      vecs++;
      if (wr_ready !== 1'b0) begin
         fails++;
         $display("FAIL pend_ready got %b exp %b", wr_ready, 1'b0);
      end
      #2 rst = 1'b1;
      #1;
      vecs++;
      if (gotv() !== 16'hFFF1) begin
         fails++;
         $display("FAIL async_reset got %h exp %h", gotv(), 16'hFFF1);
      end
      model_reset();
      wr_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < FR + 5; i++) begin
         adv();
         vecs++;
         if (gotv() !== expv()) begin
            fails++;
            $display("FAIL post_reset cyc %0d got %h exp %h", i, gotv(), expv());
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_midframe();
      test_blank_dp();
      test_en_drop();
      test_random();
      test_reset_pending();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller for an N-digit common-anode seven-segment display. Drives one shared hex-to-segment decoder (SevenSeg) from a per-digit nibble mux. Sequences digit enables with an inter-digit ghosting gap. Accepts new display contents through a valid/ready port and commits them only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=2)
TICK_DIV, 1000, clock cycles each digit is lit per slot (>=2)
GAP_CYC, 16, clock cycles with all digits off between slots (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
en  in  1  scan enable; 0 forces all digits off
wr_valid  in  1  new display contents offered
wr_ready  out  1  shadow register free; transfer when wr_valid&wr_ready
wr_data  in  4*NUM_DIGITS  hex nibbles; digit k = wr_data[4k+3:4k]
wr_blank  in  NUM_DIGITS  1 = digit k dark
wr_dp  in  NUM_DIGITS  1 = decimal point k lit
an_n  out  NUM_DIGITS  digit enables, active-low
seg_n  out  7  segments a..g, active-low (seg_n[6]=a ... seg_n[0]=g)
dp_n  out  1  decimal point, active-low
cur_digit  out  clog2(NUM_DIGITS)  index of current/last slot
frame_start  out  1  one-cycle pulse when a new frame begins at digit 0

Behaviour:
- Reset: state=IDLE, idx=0, cnt=0, an_n=all 1, seg_n=7'h7F, dp_n=1, frame_start=0, wr_ready=1, pending=0, display/shadow regs=0 (blank=all 0, dp=all 0).
- All outputs are flops. They update on the same edge the FSM enters a state, so output timing equals state timing exactly.
- IDLE: outputs off. When en=1, go to SHOW with idx=0 and cnt=0, and pulse frame_start.
- SHOW: an_n[idx]=0, or all 1 if blank[idx]. seg_n = decoder(nibble[idx]), or 7'h7F if blanked. dp_n = ~dp[idx]. cnt counts 0..TICK_DIV-1; at TICK_DIV-1 go to GAP with cnt=0.
- GAP: an_n=all 1, seg_n=7'h7F, dp_n=1. cnt counts 0..GAP_CYC-1. At the last count go to SHOW and:
  - if idx==NUM_DIGITS-1: idx wraps to 0, commit shadow if pending, pulse frame_start;
  - otherwise idx+1.
- Frame length: NUM_DIGITS*(TICK_DIV+GAP_CYC) cycles.
- en=0 in any state: next edge goes to IDLE, outputs off, idx=0, cnt=0. A pending shadow is retained.
- Handshake: on wr_valid&wr_ready, capture data/blank/dp into the shadow, set pending=1, and drop wr_ready on the next edge (wr_ready = ~pending, registered). wr_valid without wr_ready is ignored; the source must hold.
- Commit copies shadow to the display regs, clears pending, and raises wr_ready on the same edge. A commit happens in GAP->SHOW at the frame wrap, or on the cycle after capture while in IDLE.
- cur_digit=idx. It holds its value through the GAP that follows a slot.
- Counter width = clog2(max(TICK_DIV,GAP_CYC)). No overflow beyond terminal counts.
- Async reset mid-frame: all outputs go off immediately. Pending data is lost.

Decomposition:
- Shared package: SEG_OFF=7'h7F, AN_OFF (all-ones helper), state encoding IDLE/SHOW/GAP (2-bit localparams).
- One sub-module, instantiated once: SevenSeg (combinational, active-low a..g), fed by the nibble mux on idx. Its outputs are registered here.

Test Plan:
Use NUM_DIGITS=4, TICK_DIV=4, GAP_CYC=1 (frame = 20 cycles).
1. Reset, en=0 -> an_n=4'hF, seg_n=7'h7F, dp_n=1, wr_ready=1 held for 10 cycles.
2. Write wr_data=16'h3210 in IDLE, then en=1 -> frame_start is one cycle. an_n sequence: 1110 x4, 1111 x1, 1101 x4, 1111, 1011 x4, 1111, 0111 x4, 1111, then repeats. seg_n in each slot = decoder(0/1/2/3), and 7'h7F in each gap. frame_start every 20 cycles.
3. Mid-frame write 16'hABCD while scanning 16'h3210 -> wr_ready=0 until the wrap edge. Remaining slots still show 2 and 3. The next frame shows D,C,B,A. wr_ready returns to 1 on the frame_start edge.
4. wr_blank=4'b0100, wr_dp=4'b0001 -> digit 2 slot has an_n=4'hF and seg_n=7'h7F. dp_n=0 only during digit 0 slot.
5. Deassert en during digit 2 SHOW -> next edge an_n=4'hF, cur_digit=0. Re-enable -> restarts at digit 0 with frame_start.
6. Assert rst during the pending-commit window -> outputs off asynchronously, wr_ready=1, next frame shows all-zero digits.
